// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding constants for the instruction encoder and the decode stage.
// Holds the descriptor class/op enums and the opcode/funct3/funct7 field values.
package rv_enc_pkg;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_IALU   = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5
    } enc_cls_t;

    typedef enum logic [2:0] {
        AOP_ADD = 3'b000,
        AOP_OR  = 3'b001,
        AOP_SUB = 3'b010,
        AOP_SRA = 3'b011,
        AOP_SLL = 3'b100,
        AOP_SRL = 3'b101,
        AOP_XOR = 3'b110,
        AOP_AND = 3'b111
    } enc_aop_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Returns {funct7, funct3} for an R-type ALU op.
    function automatic logic [9:0] alu_funct(input enc_aop_t aop);
        logic [9:0] f;
        case (aop)
            AOP_ADD: f = {F7_BASE, F3_ADD_SUB};
            AOP_SUB: f = {F7_ALT,  F3_ADD_SUB};
            AOP_SLL: f = {F7_BASE, F3_SLL};
            AOP_XOR: f = {F7_BASE, F3_XOR};
            AOP_SRL: f = {F7_BASE, F3_SRL_SRA};
            AOP_SRA: f = {F7_ALT,  F3_SRL_SRA};
            AOP_OR:  f = {F7_BASE, F3_OR};
            default: f = {F7_BASE, F3_AND};
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// Immediate bit-scatter for each instruction format, plus the range-fail flag.
// Range checking is compiled in only when ENC_RANGE_CHECK_EN is defined.
module rv_imm_pack
    import rv_enc_pkg::*;
(
    input  enc_cls_t    cls_i,
    input  logic [31:0] imm_i,
    output logic [31:0] imm_bits_o,
    output logic        range_fail_o
);

    always_comb begin
        imm_bits_o = '0;
        case (cls_i)
            CLS_IALU, CLS_LOAD: imm_bits_o[31:20] = imm_i[11:0];
            CLS_STORE: begin
                imm_bits_o[31:25] = imm_i[11:5];
                imm_bits_o[11:7]  = imm_i[4:0];
            end
            CLS_BRANCH: begin
                imm_bits_o[31]    = imm_i[12];
                imm_bits_o[30:25] = imm_i[10:5];
                imm_bits_o[11:8]  = imm_i[4:1];
                imm_bits_o[7]     = imm_i[11];
            end
            CLS_JAL: imm_bits_o[31:12] = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12]};
            default: ;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = imm_i;

    // Branch and jump targets must be halfword aligned, so an odd offset is out of range.
    always_comb begin
        range_fail_o = 1'b0;
        case (cls_i)
            CLS_IALU, CLS_LOAD, CLS_STORE:
                range_fail_o = (simm < -32'sd2048) || (simm > 32'sd2047);
            CLS_BRANCH:
                range_fail_o = (simm < -32'sd4096) || (simm > 32'sd4094) || imm_i[0];
            CLS_JAL:
                range_fail_o = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm_i[0];
            default: ;
        endcase
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_i[31:21];
    assign range_fail_o  = 1'b0;
`endif

endmodule

// File: rtl/rv_inst_encoder.sv
// Streaming RV32I encoder: packs field descriptors into words with sequential byte addresses.
// Optional immediate range checking is enabled with the ENC_RANGE_CHECK_EN macro.
module rv_inst_encoder
    import rv_enc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_cls,
    input  logic [2:0]        in_aop,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_cnt
);

    // Handshake: a transfer happens on a rising edge where valid && ready; once out_valid is
    // raised, out_word/out_addr stay put until taken, and in_ready never depends on in_valid.
    enc_cls_t    cls;
    enc_aop_t    aop;
    logic [9:0]  r_funct;
    logic [31:0] imm_bits;
    logic        range_fail;
    logic [31:0] enc_word;
    logic        legal;
    logic        accept;
    logic        take;
    logic        reject;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_word_q,  out_word_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic              err_q,       err_d;
    logic [7:0]        err_cnt_q,   err_cnt_d;

    assign cls     = enc_cls_t'(in_cls);
    assign aop     = enc_aop_t'(in_aop);
    assign r_funct = alu_funct(aop);

    rv_imm_pack u_imm_pack (
        .cls_i        (cls),
        .imm_i        (in_imm),
        .imm_bits_o   (imm_bits),
        .range_fail_o (range_fail)
    );

    always_comb begin
        legal    = 1'b1;
        enc_word = '0;
        case (cls)
            CLS_R:      enc_word = {r_funct[9:3], in_rs2, in_rs1, r_funct[2:0], in_rd, OPC_R};
            CLS_IALU: begin
                legal    = (aop == AOP_ADD);
                enc_word = imm_bits | {12'b0, in_rs1, F3_ADD_SUB, in_rd, OPC_IALU};
            end
            CLS_LOAD:   enc_word = imm_bits | {12'b0, in_rs1, F3_WORD, in_rd, OPC_LOAD};
            CLS_STORE:  enc_word = imm_bits | {7'b0, in_rs2, in_rs1, F3_WORD, 5'b0, OPC_STORE};
            CLS_BRANCH: enc_word = imm_bits | {7'b0, in_rs2, in_rs1, F3_BEQ, 5'b0, OPC_BRANCH};
            CLS_JAL:    enc_word = imm_bits | {20'b0, in_rd, OPC_JAL};
            default:    legal = 1'b0;
        endcase
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign take     = out_valid_q && out_ready;
    assign reject   = !legal || range_fail;

    // A word accepted while the previous one drains lands at the already-advanced address.
    always_comb begin
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_addr_d  = out_addr_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_addr_d  = BASE_ADDR;
            err_d       = 1'b0;
            err_cnt_d   = '0;
        end else begin
            if (take) begin
                out_valid_d = 1'b0;
                out_addr_d  = out_addr_q + ADDR_W'(4);
            end
            if (accept) begin
                if (reject) begin
                    err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end else begin
                    out_valid_d = 1'b1;
                    out_word_d  = enc_word;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_addr_q  <= BASE_ADDR;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_addr_q  <= out_addr_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: doc/rv_inst_encoder.md
# rv_inst_encoder

Streaming RV32I instruction encoder, the inverse of the pipeline's decode stage. It accepts field-level instruction descriptors over a valid/ready handshake, packs them into 32-bit RV32I words, and emits each word with a sequential instruction-memory byte address. It feeds the instruction-memory write port and the test harness's program loader. Its encoding set matches exactly what decode understands: R-type ALU, addi, lw, sw, beq and jal.

## Interface
- ADDR_W, 32: width of the emitted byte address.
- BASE_ADDR, 0: address of the first emitted word; must be 4-byte aligned.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear: drops the held word and reloads the address to BASE_ADDR.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
- in_cls  in  3  instruction class (enum enc_cls_t): R=0, IALU=1, LOAD=2, STORE=3, BRANCH=4, JAL=5; values 6–7 are illegal.
- in_aop  in  3  ALU op (enum enc_aop_t): ADD=000, OR=001, SUB=010, SRA=011, SLL=100, SRL=101, XOR=110, AND=111.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate as a byte value; branch and jump offsets are relative to the instruction address.
- out_valid  out  1  an encoded word is held.
- out_ready  in  1  the sink takes the word when out_valid && out_ready.
- out_word  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_word.
- err  out  1  sticky: set on any rejected descriptor; cleared only by reset or flush.
- err_cnt  out  8  count of rejected descriptors; saturates at 255.

## Operation
- Opcodes:
  - R: 0110011
  - IALU: 0010011
  - LOAD: 0000011
  - STORE: 0100011
  - BRANCH: 1100011
  - JAL: 1101111
- R-type funct3/funct7 by in_aop:
  - ADD: 000/0000000
  - SUB: 000/0100000
  - SLL: 001/0000000
  - XOR: 100/0000000
  - SRL: 101/0000000
  - SRA: 101/0100000
  - OR: 110/0000000
  - AND: 111/0000000
- IALU: only in_aop=ADD is legal (addi, funct3 000). Any other in_aop is rejected.
- LOAD: lw, funct3 010. Immediate goes to [31:20].
- STORE: sw, funct3 010. Immediate bits [11:5] go to [31:25] and bits [4:0] go to [11:7].
- BRANCH: beq, funct3 000. Instruction bits = {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], opcode}.
- JAL: instruction bits = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Fields unused by a format are taken from the instruction layout only; unused descriptor inputs are ignored.
- Rejection conditions:
  - illegal in_cls;
  - illegal in_aop for IALU;
  - range failure (see Configuration).
- A rejected descriptor is consumed with no output word: err is set, err_cnt increments, and out_addr does not advance.
- Address counter:
  - starts at BASE_ADDR;
  - advances by 4 when an emitted word is taken;
  - wraps modulo 2^ADDR_W.

## Timing
- Reset values:
  - out_valid=0, out_word=0, out_addr=BASE_ADDR, err=0, err_cnt=0.
  - in_ready=1 while rst_n is high.
- in_ready = !out_valid || out_ready (combinational). A full register drains and refills in the same cycle, with no bubble.
- Latency: a descriptor accepted at edge N is visible on out_* after edge N.
- out_word and out_addr are held stable while out_valid && !out_ready.
- Back-to-back operation: one word per cycle with out_ready held high.
- Accept plus reject in the same cycle: the held word drains normally, the rejected descriptor produces nothing, and out_valid falls.
- flush has priority over a simultaneous handshake. The word is lost, and neither address nor error state records the dropped input.
- Reset asserted mid-stream: everything returns to reset values immediately, with no edge required.

## Configuration
- ENC_RANGE_CHECK_EN defined:
  - addi, lw and sw immediates must lie in [-2048, 2047];
  - beq offsets must lie in [-4096, 4094] and be even;
  - jal offsets must lie in [-2^20, 2^20-2] and be even;
  - any violation rejects the descriptor.
- ENC_RANGE_CHECK_EN undefined: immediates are silently truncated to the field bits, and bit 0 is dropped for beq/jal. Only illegal-class and illegal-op rejections remain.

## Structure
- Package rv_enc_pkg holds:
  - enc_cls_t and enc_aop_t;
  - opcode, funct3 and funct7 localparams.
- Decode imports rv_enc_pkg for the same constants.
- One combinational sub-module, rv_imm_pack, takes class and immediate and returns the immediate bit-scatter plus the range-fail flag. The top level holds the output register, the address counter and the error state.

## Test plan
- R SUB, rd=3, rs1=1, rs2=2 with out_ready=1 → out_word=0x402081B3, out_addr=0x0, out_valid one cycle after accept.
- Stream addi x1,x0,5 / sw x1,8(x0) / lw x2,8(x0) with out_ready=1 → words 0x00500093, 0x00102423, 0x00802103 at addresses 0x0, 0x4, 0x8.
- beq x1,x2,-8 with out_ready low for 3 cycles → out_word=0xFE208CE3 held stable, in_ready=0 until out_ready rises.
- addi with imm=4096, ENC_RANGE_CHECK_EN defined → no output, err=1, err_cnt=1, next word still at the same address. With the macro undefined → the word is emitted with imm field 0x000.
- jal x1,+2048 → 0x001000EF. IALU with aop=SUB → rejected. 256 illegal-class descriptors → err_cnt saturates at 255.
- flush asserted while a word is held and out_ready=0 → out_valid=0, out_addr=BASE_ADDR, err cleared. rst_n pulsed mid-stream → reset values appear asynchronously.
